// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: opcodes, FSM states,
// counter width default and the constant branch-offset table.
package branch_ctrl_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int LUT_DEPTH_DEF = 32;
  localparam int LUT_IDX_W     = 5;
  localparam int TGT_W         = 10;
  localparam int INSTR_W       = 9;

  localparam logic [2:0] OP_BR   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Two's-complement offsets; the fetch stage adds them modulo 2^10.
  localparam logic [TGT_W-1:0] BR_LUT [LUT_DEPTH_DEF] = '{
    10'sd0,    10'sd2,    -10'sd3,   10'sd4,    -10'sd5,   10'sd8,
    -10'sd8,   10'sd16,   -10'sd16,  10'sd32,   -10'sd32,  10'sd64,
    -10'sd64,  10'sd100,  -10'sd100, 10'sd128,  -10'sd128, 10'sd200,
    -10'sd200, 10'sd256,  -10'sd256, 10'sd300,  -10'sd300, 10'sd400,
    -10'sd400, 10'sd500,  -10'sd500, 10'sd511,  -10'sd512, 10'sd7,
    -10'sd7,   -10'sd1
  };

endpackage

// File: rtl/branch_ctrl_if.sv
// Harness-side bundle of the branch controller: launch control, instruction
// stream, branch request outputs, status and counters.
interface branch_ctrl_if
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  // No valid/ready pair here: Start is a level request sampled every posedge,
  // InstrIn/ALU_flag are valid every cycle, and the fetch stage must accept
  // BranchRelEn/Target in the same cycle they are presented.
  logic                 Start;
  logic [INSTR_W-1:0]   InstrIn;
  logic                 ALU_flag;
  logic                 BranchRelEn;
  logic [TGT_W-1:0]     Target;
  logic                 Done;
  logic                 Timeout;
  logic [CNT_W-1:0]     CycleCount;
  logic [CNT_W-1:0]     TakenCount;
  state_e               dbg_state;

  modport master (
    output Start, InstrIn, ALU_flag,
    input  BranchRelEn, Target, Done, Timeout, CycleCount, TakenCount, dbg_state
  );

  modport slave (
    input  Start, InstrIn, ALU_flag,
    output BranchRelEn, Target, Done, Timeout, CycleCount, TakenCount, dbg_state
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational branch-offset lookup: 5-bit index to 10-bit signed offset.
module branch_lut
  import branch_ctrl_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH_DEF
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [TGT_W-1:0]     offset_o
);

  always_comb begin
    offset_o = '0;
    if (int'(idx_i) < DEPTH) offset_o = BR_LUT[idx_i];
  end

endmodule

// File: rtl/branch_ctrl.sv
// Program sequencer: launches on Start, raises relative-branch requests from
// decoded instructions, and counts run cycles and taken branches.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int LUT_DEPTH = LUT_DEPTH_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  branch_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic             timeout_q, timeout_d;
  logic             done_q;

  logic [2:0]       opcode;
  logic             is_br, is_halt;
  logic [TGT_W-1:0] lut_off;

  assign opcode  = bus.InstrIn[8:6];
  assign is_br   = (opcode == OP_BR);
  assign is_halt = (opcode == OP_HALT) && (bus.InstrIn[5:0] == '0);

  branch_lut #(.DEPTH(LUT_DEPTH)) u_lut (
    .idx_i    (bus.InstrIn[4:0]),
    .offset_o (lut_off)
  );

  // Target is held at 0 in IDLE so it also reads 0 while reset is asserted.
  assign bus.BranchRelEn = (state_q == S_RUN) && is_br;
  assign bus.Target      = (is_br && (state_q != S_IDLE)) ? lut_off : '0;
  assign bus.Done        = done_q;
  assign bus.Timeout     = timeout_q;
  assign bus.CycleCount  = cycle_q;
  assign bus.TakenCount  = taken_q;
  assign bus.dbg_state   = state_q;

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    taken_d   = taken_q;
    timeout_d = timeout_q;
    unique case (state_q)
      S_IDLE:  if (bus.Start) state_d = S_ARMED;
      S_ARMED: if (!bus.Start) state_d = S_RUN;
      S_RUN: begin
        if (bus.Start) begin
          state_d = S_ARMED;
        end else begin
          if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
          if (bus.BranchRelEn && bus.ALU_flag && (taken_q != '1))
            taken_d = taken_q + 1'b1;
          // Halt takes priority over saturation, so Timeout is only for runaways.
          if (is_halt) begin
            state_d = S_DONE;
          end else if (cycle_q == '1) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      S_DONE:  if (bus.Start) state_d = S_ARMED;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ARMED) begin
      cycle_d   = '0;
      taken_d   = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cycle_q   <= '0;
      taken_q   <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      taken_q   <= taken_d;
      timeout_q <= timeout_d;
      done_q    <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance run side by side against a program-level reference model.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  branch_ctrl_if #(.CNT_W(16)) ifa ();
  branch_ctrl_if #(.CNT_W(4))  ifb ();

  branch_ctrl #(.CNT_W(16)) u_a (.Clk(Clk), .Reset(Reset), .bus(ifa.slave));
  branch_ctrl #(.CNT_W(4))  u_b (.Clk(Clk), .Reset(Reset), .bus(ifb.slave));

  int n_assert = 0;
  int n_fail   = 0;

  // Offsets written as plain signed integers.
  int lut_int [32] = '{0, 2, -3, 4, -5, 8, -8, 16, -16, 32, -32, 64, -64, 100,
                       -100, 128, -128, 200, -200, 256, -256, 300, -300, 400,
                       -400, 500, -500, 511, -512, 7, -7, -1};

  state_e m_mode [2];
  int     m_cyc  [2];
  int     m_tak  [2];
  int     m_max  [2];
  bit     m_to   [2];

  localparam logic [8:0] NOP  = 9'h000;
  localparam logic [8:0] HALT = 9'h1C0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset(int d);
    m_mode[d] = S_IDLE;
    m_cyc[d]  = 0;
    m_tak[d]  = 0;
    m_to[d]   = 1'b0;
  endfunction

  function automatic void model_arm(int d);
    m_mode[d] = S_ARMED;
    m_cyc[d]  = 0;
    m_tak[d]  = 0;
    m_to[d]   = 1'b0;
  endfunction

  function automatic void model_edge(int d, bit s, logic [8:0] ins, bit f);
    bit br, halt, full;
    br   = (ins[8:6] == 3'b110);
    halt = (ins == HALT);
    case (m_mode[d])
      S_IDLE:  if (s) model_arm(d);
      S_ARMED: if (!s) m_mode[d] = S_RUN;
      S_RUN: begin
        if (s) begin
          model_arm(d);
        end else begin
          full = (m_cyc[d] == m_max[d]);
          m_cyc[d] = (m_cyc[d] + 1 > m_max[d]) ? m_max[d] : m_cyc[d] + 1;
          if (br && f) m_tak[d] = (m_tak[d] + 1 > m_max[d]) ? m_max[d] : m_tak[d] + 1;
          if (halt) m_mode[d] = S_DONE;
          else if (full) begin
            m_mode[d] = S_DONE;
            m_to[d]   = 1'b1;
          end
        end
      end
      default: if (s) model_arm(d);
    endcase
  endfunction

  task automatic check_comb(int d, logic [8:0] ins);
    logic       bre, exp_bre;
    logic [9:0] tgt, exp_tgt;
    string      p;
    p = (d == 0) ? "A" : "B";
    if (d == 0) begin bre = ifa.BranchRelEn; tgt = ifa.Target; end
    else        begin bre = ifb.BranchRelEn; tgt = ifb.Target; end
    exp_bre = (m_mode[d] == S_RUN) && (ins[8:6] == 3'b110);
    exp_tgt = ((ins[8:6] == 3'b110) && (m_mode[d] != S_IDLE)) ? 10'(lut_int[ins[4:0]]) : 10'd0;
    chk({p, ".branch_rel_en"}, 32'(bre), 32'(exp_bre));
    chk({p, ".target"}, 32'(tgt), 32'(exp_tgt));
  endtask

  task automatic check_regs(int d);
    logic [15:0] cyc, tak;
    logic        dn, to;
    state_e      st;
    string       p;
    p = (d == 0) ? "A" : "B";
    if (d == 0) begin
      cyc = ifa.CycleCount; tak = ifa.TakenCount; dn = ifa.Done; to = ifa.Timeout; st = ifa.dbg_state;
    end else begin
      cyc = 16'(ifb.CycleCount); tak = 16'(ifb.TakenCount); dn = ifb.Done; to = ifb.Timeout; st = ifb.dbg_state;
    end
    chk({p, ".state"}, 32'(st), 32'(m_mode[d]));
    chk({p, ".done"}, 32'(dn), 32'(m_mode[d] == S_DONE));
    chk({p, ".timeout"}, 32'(to), 32'(m_to[d]));
    chk({p, ".cycle_count"}, 32'(cyc), 32'(m_cyc[d]));
    chk({p, ".taken_count"}, 32'(tak), 32'(m_tak[d]));
  endtask

  // Called with the clock low; returns at the following negedge.
  task automatic step(input bit s0, input logic [8:0] i0, input bit f0,
                      input bit s1, input logic [8:0] i1, input bit f1);
    ifa.Start = s0; ifa.InstrIn = i0; ifa.ALU_flag = f0;
    ifb.Start = s1; ifb.InstrIn = i1; ifb.ALU_flag = f1;
    #1;
    check_comb(0, i0);
    check_comb(1, i1);
    @(posedge Clk);
    model_edge(0, s0, i0, f0);
    model_edge(1, s1, i1, f1);
    #1;
    check_regs(0);
    check_regs(1);
    @(negedge Clk);
  endtask

  task automatic step_a(input bit s, input logic [8:0] i, input bit f);
    step(s, i, f, 1'b0, NOP, 1'b0);
  endtask

  task automatic step_b(input bit s, input logic [8:0] i, input bit f);
    step(1'b0, NOP, 1'b0, s, i, f);
  endtask

  task automatic check_reset_zero();
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      check_comb(d, (d == 0) ? ifa.InstrIn : ifb.InstrIn);
      check_regs(d);
    end
  endtask

  // Reset asserted between edges; outputs must clear before the next posedge.
  task automatic mid_cycle_reset();
    ifa.InstrIn = 9'b110_0_00010;
    ifb.InstrIn = 9'b110_0_11111;
    #1 Reset = 1'b1;
    #1 check_reset_zero();
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    logic [8:0] ra, rb;
    m_max[0] = 65535;
    m_max[1] = 15;
    model_reset(0);
    model_reset(1);

    Reset = 1'b1;
    ifa.Start = 1'b1; ifa.InstrIn = 9'b110_0_00001; ifa.ALU_flag = 1'b1;
    ifb.Start = 1'b0; ifb.InstrIn = NOP;           ifb.ALU_flag = 1'b0;
    #1 check_reset_zero();
    @(negedge Clk);
    Reset = 1'b0;

    // Launch A: Start held -> ARMED, drop Start -> RUN; branch in ARMED is ignored.
    step_a(1'b1, NOP, 1'b0);
    step_a(1'b1, NOP, 1'b0);
    step_a(1'b0, 9'b110_0_00010, 1'b1);
    step_a(1'b0, 9'b110_0_00010, 1'b1);
    chk("A.taken_after_branch", 32'(ifa.TakenCount), 32'd1);
    step_a(1'b0, 9'b110_0_00010, 1'b0);
    step_a(1'b0, 9'b110_1_00010, 1'b1);
    step_a(1'b0, 9'b110_0_11111, 1'b1);
    step_a(1'b0, 9'b110_0_00000, 1'b1);
    step_a(1'b0, 9'h1C1, 1'b0);
    chk("A.taken_sequence", 32'(ifa.TakenCount), 32'd4);

    // Fresh program: five run cycles then halt.
    step_a(1'b1, NOP, 1'b0);
    step_a(1'b0, NOP, 1'b0);
    for (int i = 0; i < 5; i++) step_a(1'b0, NOP, 1'b0);
    step_a(1'b0, HALT, 1'b0);
    chk("A.halt_done", 32'(ifa.Done), 32'd1);
    chk("A.halt_cycles", 32'(ifa.CycleCount), 32'd6);
    chk("A.halt_timeout", 32'(ifa.Timeout), 32'd0);
    step_a(1'b0, NOP, 1'b0);
    step_a(1'b1, NOP, 1'b0);
    chk("A.restart_cleared", 32'(ifa.CycleCount), 32'd0);

    // Start and halt in the same run cycle: Start wins.
    step_a(1'b0, NOP, 1'b0);
    step_a(1'b0, NOP, 1'b0);
    step_a(1'b1, HALT, 1'b0);
    chk("A.start_over_halt", 32'(ifa.dbg_state), 32'(S_ARMED));

    // Narrow counters: run into saturation, then halt exactly at saturation.
    step_b(1'b1, NOP, 1'b0);
    step_b(1'b0, NOP, 1'b0);
    for (int i = 0; i < 15; i++) step_b(1'b0, 9'b110_0_00011, 1'b1);
    chk("B.pre_sat_done", 32'(ifb.Done), 32'd0);
    step_b(1'b0, NOP, 1'b0);
    chk("B.sat_done", 32'(ifb.Done), 32'd1);
    chk("B.sat_timeout", 32'(ifb.Timeout), 32'd1);
    chk("B.sat_cycles", 32'(ifb.CycleCount), 32'd15);
    chk("B.sat_taken", 32'(ifb.TakenCount), 32'd15);
    step_b(1'b1, NOP, 1'b0);
    step_b(1'b0, NOP, 1'b0);
    for (int i = 0; i < 15; i++) step_b(1'b0, NOP, 1'b0);
    step_b(1'b0, HALT, 1'b0);
    chk("B.halt_at_sat_done", 32'(ifb.Done), 32'd1);
    chk("B.halt_at_sat_timeout", 32'(ifb.Timeout), 32'd0);

    // Random programs on both instances.
    for (int n = 0; n < 600; n++) begin
      ra = (($urandom_range(0, 99) < 45) ? {3'b110, 6'($urandom_range(0, 63))} :
            ($urandom_range(0, 99) < 8) ? HALT : 9'($urandom));
      rb = (($urandom_range(0, 99) < 45) ? {3'b110, 6'($urandom_range(0, 63))} :
            ($urandom_range(0, 99) < 4) ? HALT : 9'($urandom));
      step($urandom_range(0, 99) < 4, ra, 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 3, rb, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a running program.
    step(1'b1, NOP, 1'b0, 1'b1, NOP, 1'b0);
    step(1'b0, NOP, 1'b0, 1'b0, NOP, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 9'b110_0_00101, 1'b1, 1'b0, 9'b110_0_00101, 1'b1);
    mid_cycle_reset();
    step_a(1'b0, NOP, 1'b0);
    chk("A.idle_after_reset", 32'(ifa.dbg_state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter: LUT_DEPTH, default 32, number of branch-offset entries; index width = 5.
REQ-002 Parameter: CNT_W, default 16, width of cycle and branch counters.
REQ-003 Clk  input  1  single clock; all state changes on posedge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state.
REQ-005 Start  input  1  program-launch request from test harness.
REQ-006 InstrIn  input  9  instruction word read from instruction memory at the current program counter.
REQ-007 ALU_flag  input  1  branch condition from ALU, same cycle as InstrIn.
REQ-008 BranchRelEn  output  1  relative-branch request to fetch stage.
REQ-009 Target  output  10  signed relative branch offset to fetch stage.
REQ-010 Done  output  1  program finished (halt or timeout).
REQ-011 Timeout  output  1  program ended by cycle-counter saturation.
REQ-012 CycleCount  output  CNT_W  RUN cycles in the current program.
REQ-013 TakenCount  output  CNT_W  branches taken in the current program.

Function
REQ-014 Decode: opcode = InstrIn[8:6]; OP_BR = 3'b110, OP_HALT = 3'b111 with InstrIn[5:0] = 0; OP_HALT with nonzero [5:0] is a no-op.
REQ-015 FSM states: IDLE, ARMED, RUN, DONE.
REQ-016 IDLE -> ARMED when Start = 1.
REQ-017 ARMED holds while Start = 1; ARMED -> RUN on the first cycle Start = 0.
REQ-018 RUN -> DONE on the cycle an OP_HALT is present.
REQ-019 RUN -> DONE with Timeout set when CycleCount = all-ones and no halt is present.
REQ-020 DONE holds until Start = 1, then -> ARMED.
REQ-021 Start = 1 in RUN -> ARMED, abandoning the program.
REQ-022 BranchRelEn is combinational: 1 only when state = RUN and opcode = OP_BR; 0 in every other state.
REQ-023 Target is combinational: LUT[InstrIn[4:0]] when opcode = OP_BR, else 0.
REQ-024 Target is a 10-bit two's-complement offset; the fetch stage adds it modulo 2^10, so the wrap-around is intended.
REQ-025 LUT is a constant table: entry 0 = 0, entry 1 = +2, entry 2 = -3 (10'h3FD), entry 31 = -1 (10'h3FF); the remaining entries are fixed in the package.
REQ-026 Entering ARMED clears CycleCount, TakenCount and Timeout.
REQ-027 CycleCount increments by 1 on every RUN cycle, including the halt cycle, and saturates at all-ones.
REQ-028 TakenCount increments when BranchRelEn = 1 and ALU_flag = 1, and saturates at all-ones.
REQ-029 Done is registered and equals 1 exactly when state = DONE.
REQ-030 Halt and saturation in the same cycle: halt wins, and Timeout stays 0.
REQ-031 Start and halt in the same RUN cycle: Start wins, and the next state is ARMED.
REQ-032 InstrIn bits 5 of OP_BR are ignored.

Reset
REQ-033 On Reset: state = IDLE, Done = 0, Timeout = 0, CycleCount = 0, TakenCount = 0.
REQ-034 BranchRelEn and Target read 0 during reset and in IDLE.
REQ-035 Reset asserted mid-RUN takes effect immediately, without waiting for a clock edge.

Structure
REQ-036 The shared package holds: the opcode constants OP_BR and OP_HALT, the state enum, the LUT contents as a constant array, and the default CNT_W.
REQ-037 One sub-module, branch_lut: a combinational 5-bit-index to 10-bit-offset lookup; FSM and counters stay in branch_ctrl.

Verification
REQ-038 Reset with Start high -> IDLE and all outputs 0; release Reset -> ARMED next edge; drop Start -> RUN next edge.
REQ-039 RUN, InstrIn = 9'b110_0_00010, ALU_flag = 1 -> BranchRelEn = 1 and Target = 10'h3FD same cycle; TakenCount +1 next edge.
REQ-040 Same branch with ALU_flag = 0 -> BranchRelEn = 1 and TakenCount unchanged. Same branch in ARMED -> BranchRelEn = 0.
REQ-041 RUN for 5 cycles, then InstrIn = 9'h1C0 -> Done = 1 next edge, CycleCount = 6, Timeout = 0; Start pulse -> counters cleared.
REQ-042 CNT_W = 4 with no halt -> Done = 1 and Timeout = 1 after CycleCount reaches 15; halt in that saturating cycle -> Timeout = 0.
REQ-043 Reset asserted mid-RUN between clock edges -> state IDLE and counters 0 before the next posedge.
